// File: rtl/algo_sched_pkg.sv
// Shared types, constants and helpers for the 2R2W port scheduler.
// Performance counters are enabled in the top with ALGO_SCHED_PERF_CNT_EN.
package algo_sched_pkg;
   localparam int TAG_IDX_W = 2;   // matches the scheduler's BITREQ
   localparam int CNT_W     = 16;

   typedef struct packed {
      logic                 vld;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction
endpackage

// File: rtl/algo_rr_pick2.sv
// Round-robin picker: up to two grants from a request vector starting at a
// pointer; the second pick is further qualified by mask2_i.
module algo_rr_pick2
   import algo_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int BW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [BW-1:0] ptr_i,
   input  logic [N-1:0]  mask2_i,
   output logic          vld0_o,
   output logic [BW-1:0] idx0_o,
   output logic          vld1_o,
   output logic [BW-1:0] idx1_o,
   output logic [BW-1:0] ptr_nxt_o
);
   function automatic logic [BW-1:0] wrap_add(input logic [BW-1:0] b, input int k);
      return BW'((int'(b) + k) % N);
   endfunction

   // First pick: descending scan so the candidate nearest the pointer wins.
   always_comb begin
      vld0_o = 1'b0;
      idx0_o = '0;
      for (int k = N-1; k >= 0; k--) begin
         vld0_o = vld0_o | req_i[wrap_add(ptr_i, k)];
         idx0_o = req_i[wrap_add(ptr_i, k)] ? wrap_add(ptr_i, k) : idx0_o;
      end
   end

   // Second pick: continue the scan after the first grant, honouring the mask.
   always_comb begin
      vld1_o = 1'b0;
      idx1_o = '0;
      for (int k = N-1; k >= 1; k--) begin
         vld1_o = vld1_o | (vld0_o & req_i[wrap_add(idx0_o, k)] & mask2_i[wrap_add(idx0_o, k)]);
         idx1_o = (vld0_o & req_i[wrap_add(idx0_o, k)] & mask2_i[wrap_add(idx0_o, k)])
                  ? wrap_add(idx0_o, k) : idx1_o;
      end
   end

   assign ptr_nxt_o = vld0_o ? wrap_add(vld1_o ? idx1_o : idx0_o, 1) : ptr_i;
endmodule

// File: rtl/algo_2r2w_port_sched.sv
// Schedules NUMREQ requesters onto a 2-read/2-write memory and routes read data
// back by tag. Define ALGO_SCHED_PERF_CNT_EN to add the grant/stall counters.
module algo_2r2w_port_sched
   import algo_sched_pkg::*;
#(
   parameter int NUMREQ   = 4,
   parameter int BITREQ   = 2,
   parameter int WIDTH    = 15,
   parameter int BITADDR  = 8,
   parameter int RD_DELAY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUMREQ-1:0]         req_vld,
   input  logic [NUMREQ-1:0]         req_wr,
   input  logic [NUMREQ*BITADDR-1:0] req_adr,
   input  logic [NUMREQ*WIDTH-1:0]   req_din,
   input  logic [NUMREQ*WIDTH-1:0]   req_bw,
   output logic [NUMREQ-1:0]         req_rdy,
   output logic [1:0]                read,
   output logic [2*BITADDR-1:0]      rd_adr,
   input  logic [2*WIDTH-1:0]        rd_dout,
   input  logic [1:0]                rd_vld,
   output logic [1:0]                write,
   output logic [2*BITADDR-1:0]      wr_adr,
   output logic [2*WIDTH-1:0]        din,
   output logic [2*WIDTH-1:0]        bw,
   output logic [NUMREQ-1:0]         rsp_vld,
   output logic [NUMREQ*WIDTH-1:0]   rsp_data,
   output logic                      err
`ifdef ALGO_SCHED_PERF_CNT_EN
   ,output logic [CNT_W-1:0]         rd_gnt_cnt
   ,output logic [CNT_W-1:0]         wr_gnt_cnt
   ,output logic [CNT_W-1:0]         stall_cnt
`endif
);
   logic [BITREQ-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic                      rd_g0_s, rd_g1_s, wr_g0_s, wr_g1_s;
   logic [BITREQ-1:0]         rd_i0_s, rd_i1_s, wr_i0_s, wr_i1_s;
   logic [1:0][BITREQ-1:0]    rd_idx_s, wr_idx_s;
   logic [1:0]                rd_en_s, wr_en_s;
   logic [NUMREQ-1:0]         wr_mask_s;
   logic [NUMREQ-1:0]         rsp_vld_q, rsp_vld_d;
   logic [NUMREQ*WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic                      err_q, err_d;
   tag_t                      tag_q [2][RD_DELAY];
   tag_t                      tag_in_s [2];
   tag_t                      head_s [2];

   algo_rr_pick2 #(.N(NUMREQ), .BW(BITREQ)) u_rd_pick (
      .req_i(req_vld & ~req_wr), .ptr_i(rd_ptr_q), .mask2_i({NUMREQ{1'b1}}),
      .vld0_o(rd_g0_s), .idx0_o(rd_i0_s), .vld1_o(rd_g1_s), .idx1_o(rd_i1_s),
      .ptr_nxt_o(rd_ptr_d)
   );

   algo_rr_pick2 #(.N(NUMREQ), .BW(BITREQ)) u_wr_pick (
      .req_i(req_vld & req_wr), .ptr_i(wr_ptr_q), .mask2_i(wr_mask_s),
      .vld0_o(wr_g0_s), .idx0_o(wr_i0_s), .vld1_o(wr_g1_s), .idx1_o(wr_i1_s),
      .ptr_nxt_o(wr_ptr_d)
   );

   // A second write may not target the first granted write's address.
   always_comb begin
      wr_mask_s = '0;
      for (int i = 0; i < NUMREQ; i++) begin
         wr_mask_s[i] = req_adr[i*BITADDR +: BITADDR] != req_adr[int'(wr_i0_s)*BITADDR +: BITADDR];
      end
   end

   assign rd_en_s  = {rd_g1_s, rd_g0_s} & {2{rst}};
   assign wr_en_s  = {wr_g1_s, wr_g0_s} & {2{rst}};
   assign rd_idx_s = {rd_i1_s, rd_i0_s};
   assign wr_idx_s = {wr_i1_s, wr_i0_s};
   assign read     = rd_en_s;
   assign write    = wr_en_s;

   // Memory port muxing and per-requester ready.
   always_comb begin
      rd_adr  = '0;
      wr_adr  = '0;
      din     = '0;
      bw      = '0;
      req_rdy = '0;
      for (int p = 0; p < 2; p++) begin
         rd_adr[p*BITADDR +: BITADDR] = rd_en_s[p] ? req_adr[int'(rd_idx_s[p])*BITADDR +: BITADDR] : '0;
         wr_adr[p*BITADDR +: BITADDR] = wr_en_s[p] ? req_adr[int'(wr_idx_s[p])*BITADDR +: BITADDR] : '0;
         din[p*WIDTH +: WIDTH]        = wr_en_s[p] ? req_din[int'(wr_idx_s[p])*WIDTH +: WIDTH] : '0;
         bw[p*WIDTH +: WIDTH]         = wr_en_s[p] ? req_bw[int'(wr_idx_s[p])*WIDTH +: WIDTH] : '0;
         for (int i = 0; i < NUMREQ; i++) begin
            req_rdy[i] = req_rdy[i] | (rd_en_s[p] & (rd_idx_s[p] == BITREQ'(i)))
                                    | (wr_en_s[p] & (wr_idx_s[p] == BITREQ'(i)));
         end
      end
   end

   // Tag entering each port's pipeline and the tag due back this cycle.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         tag_in_s[p].vld = rd_en_s[p];
         tag_in_s[p].idx = TAG_IDX_W'(rd_idx_s[p]);
         head_s[p]       = tag_q[p][RD_DELAY-1];
      end
   end

   // Response steering; a slot whose rd_vld disagrees with its tag is dropped.
   always_comb begin
      rsp_vld_d  = '0;
      rsp_data_d = rsp_data_q;
      err_d      = err_q;
      for (int p = 0; p < 2; p++) begin
         err_d = err_d | (rd_vld[p] ^ head_s[p].vld);
         for (int i = 0; i < NUMREQ; i++) begin
            rsp_vld_d[i] = rsp_vld_d[i] | (rd_vld[p] & head_s[p].vld & (head_s[p].idx == TAG_IDX_W'(i)));
            rsp_data_d[i*WIDTH +: WIDTH] = (rd_vld[p] & head_s[p].vld & (head_s[p].idx == TAG_IDX_W'(i)))
                                           ? rd_dout[p*WIDTH +: WIDTH] : rsp_data_d[i*WIDTH +: WIDTH];
         end
      end
   end

   // Tag shift registers, one per read port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < RD_DELAY; s++) begin
               tag_q[p][s] <= '0;
            end
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            tag_q[p][0] <= tag_in_s[p];
            for (int s = 1; s < RD_DELAY; s++) begin
               tag_q[p][s] <= tag_q[p][s-1];
            end
         end
      end
   end

   // Pointers, responses and sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
         err_q      <= err_d;
      end
   end

   assign rsp_vld  = rsp_vld_q;
   assign rsp_data = rsp_data_q;
   assign err      = err_q;

`ifdef ALGO_SCHED_PERF_CNT_EN
   logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q, stall_q;

   // Saturating grant and stall counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         stall_q  <= '0;
      end else begin
         rd_cnt_q <= sat_add(rd_cnt_q, {1'b0, rd_en_s[0]} + {1'b0, rd_en_s[1]});
         wr_cnt_q <= sat_add(wr_cnt_q, {1'b0, wr_en_s[0]} + {1'b0, wr_en_s[1]});
         stall_q  <= sat_add(stall_q, {1'b0, |(req_vld & ~req_rdy)});
      end
   end

   assign rd_gnt_cnt = rd_cnt_q;
   assign wr_gnt_cnt = wr_cnt_q;
   assign stall_cnt  = stall_q;
`endif
endmodule

// File: tb/tb_algo_2r2w_port_sched.sv
// Directed bench for algo_2r2w_port_sched with a 1-cycle 2R2W memory model.
// Counter checks are compiled in when ALGO_SCHED_PERF_CNT_EN is defined.
module tb_algo_2r2w_port_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_vld, req_wr, req_rdy;
   logic [31:0] req_adr;
   logic [59:0] req_din, req_bw;
   logic [1:0]  read, write, rd_vld;
   logic [15:0] rd_adr, wr_adr;
   logic [29:0] rd_dout, din, bw;
   logic [3:0]  rsp_vld;
   logic [59:0] rsp_data;
   logic        err;
`ifdef ALGO_SCHED_PERF_CNT_EN
   logic [15:0] rd_gnt_cnt, wr_gnt_cnt, stall_cnt;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   logic [14:0] mem [256];
   logic [1:0]  mem_vld = 2'b00;
   logic [29:0] mem_dout = 30'h0;
   logic [1:0]  inj_vld;
   logic        pl_en;
   logic [7:0]  pl_adr;
   logic [14:0] pl_dat;

   assign rd_vld  = mem_vld | inj_vld;
   assign rd_dout = mem_dout;

   algo_2r2w_port_sched dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_wr(req_wr), .req_adr(req_adr),
      .req_din(req_din), .req_bw(req_bw), .req_rdy(req_rdy),
      .read(read), .rd_adr(rd_adr), .rd_dout(rd_dout), .rd_vld(rd_vld),
      .write(write), .wr_adr(wr_adr), .din(din), .bw(bw),
      .rsp_vld(rsp_vld), .rsp_data(rsp_data), .err(err)
`ifdef ALGO_SCHED_PERF_CNT_EN
      , .rd_gnt_cnt(rd_gnt_cnt), .wr_gnt_cnt(wr_gnt_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: reads return pre-write contents one cycle later.
   always @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         mem_vld[p] <= read[p];
         mem_dout[p*15 +: 15] <= read[p] ? mem[rd_adr[p*8 +: 8]] : 15'h0;
         if (write[p])
            mem[wr_adr[p*8 +: 8]] <= (mem[wr_adr[p*8 +: 8]] & ~bw[p*15 +: 15]) | (din[p*15 +: 15] & bw[p*15 +: 15]);
      end
      if (pl_en) mem[pl_adr] <= pl_dat;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      req_vld = 4'h0; req_wr = 4'h0; req_adr = 32'h0; req_din = 60'h0; req_bw = 60'h0;
   endtask

   task automatic set_rd(input int i, input logic [7:0] adr);
      req_vld[i] = 1'b1; req_wr[i] = 1'b0; req_adr[i*8 +: 8] = adr;
   endtask

   task automatic set_wr(input int i, input logic [7:0] adr, input logic [14:0] d, input logic [14:0] m);
      req_vld[i] = 1'b1; req_wr[i] = 1'b1; req_adr[i*8 +: 8] = adr;
      req_din[i*15 +: 15] = d; req_bw[i*15 +: 15] = m;
   endtask

   task automatic preload(input logic [7:0] adr, input logic [14:0] d);
      pl_adr = adr; pl_dat = d; pl_en = 1'b1;
      tick();
      pl_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      clr_req(); inj_vld = 2'b00; pl_en = 1'b0; pl_adr = 8'h0; pl_dat = 15'h0;
      req_vld = 4'hF;
      #2;
      chk("rst_rdy", 64'(req_rdy), 64'h0);
      chk("rst_read", 64'(read), 64'h0);
      chk("rst_write", 64'(write), 64'h0);
      chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
      chk("rst_rsp_data", 64'(rsp_data), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      clr_req();
      preload(8'h40, 15'h0A0A);
      preload(8'h41, 15'h0B0B);
      preload(8'h42, 15'h0C0C);
      preload(8'h43, 15'h0D0D);
      preload(8'h20, 15'h1234);
      rst = 1'b1;
      tick();

      // Four reads, two per cycle from pointer 0.
      set_rd(0, 8'h40); set_rd(1, 8'h41); set_rd(2, 8'h42); set_rd(3, 8'h43); #1;
      chk("s1_c0_rdy", 64'(req_rdy), 64'h3);
      chk("s1_c0_read", 64'(read), 64'h3);
      chk("s1_c0_rd_adr", 64'(rd_adr), 64'h4140);
      chk("s1_c0_write", 64'(write), 64'h0);
      tick(); req_vld[0] = 1'b0; req_vld[1] = 1'b0; #1;
      chk("s1_c1_rdy", 64'(req_rdy), 64'hC);
      chk("s1_c1_rd_adr", 64'(rd_adr), 64'h4342);
      chk("s1_c1_rsp_vld", 64'(rsp_vld), 64'h0);
      tick(); clr_req(); #1;
      chk("s1_c2_rsp_vld", 64'(rsp_vld), 64'h3);
      chk("s1_c2_data0", 64'(rsp_data[14:0]), 64'h0A0A);
      chk("s1_c2_data1", 64'(rsp_data[29:15]), 64'h0B0B);
      tick(); #1;
      chk("s1_c3_rsp_vld", 64'(rsp_vld), 64'hC);
      chk("s1_c3_data2", 64'(rsp_data[44:30]), 64'h0C0C);
      chk("s1_c3_data3", 64'(rsp_data[59:45]), 64'h0D0D);
      tick(); #1;
      chk("s1_c4_rsp_vld", 64'(rsp_vld), 64'h0);

      // Write collision on 0x10.
      set_wr(1, 8'h10, 15'h1111, 15'h7FFF); set_wr(2, 8'h10, 15'h2222, 15'h7FFF); #1;
      chk("s2_c0_rdy", 64'(req_rdy), 64'h2);
      chk("s2_c0_write", 64'(write), 64'h1);
      chk("s2_c0_wr_adr", 64'(wr_adr), 64'h0010);
      chk("s2_c0_din", 64'(din), 64'h1111);
      chk("s2_c0_bw", 64'(bw), 64'h7FFF);
      tick(); req_vld[1] = 1'b0; #1;
      chk("s2_c1_rdy", 64'(req_rdy), 64'h4);
      chk("s2_c1_din", 64'(din), 64'h2222);
      tick(); clr_req();
      set_wr(0, 8'h30, 15'h0030, 15'h7FFF); set_wr(3, 8'h31, 15'h0031, 15'h00FF); #1;
      chk("s2_c2_rdy", 64'(req_rdy), 64'h9);
      chk("s2_c2_write", 64'(write), 64'h3);
      chk("s2_c2_wr_adr", 64'(wr_adr), 64'h3031);
      chk("s2_c2_din", 64'(din), 64'h180031);
      chk("s2_c2_bw", 64'(bw), 64'h3FFF80FF);
      tick(); clr_req();

      // Same-address read and write; also read back the collided address.
      set_rd(0, 8'h20); set_wr(1, 8'h20, 15'h0555, 15'h7FFF); set_rd(2, 8'h10); #1;
      chk("s3_rdy", 64'(req_rdy), 64'h7);
      chk("s3_read", 64'(read), 64'h3);
      chk("s3_rd_adr", 64'(rd_adr), 64'h1020);
      chk("s3_write", 64'(write), 64'h1);
      chk("s3_wr_adr", 64'(wr_adr), 64'h0020);
      tick(); clr_req(); #1;
      tick(); #1;
      chk("s3_rsp_vld", 64'(rsp_vld), 64'h5);
      chk("s3_data0", 64'(rsp_data[14:0]), 64'h1234);
      chk("s3_data2", 64'(rsp_data[44:30]), 64'h2222);
      tick(); set_rd(3, 8'h20); #1;
      chk("s3b_read", 64'(read), 64'h1);
      chk("s3b_rd_adr", 64'(rd_adr), 64'h0020);
      tick(); clr_req(); #1;
      tick(); #1;
      chk("s3b_rsp_vld", 64'(rsp_vld), 64'h8);
      chk("s3b_data3", 64'(rsp_data[59:45]), 64'h0555);

      // Spurious rd_vld with no tag outstanding.
      inj_vld = 2'b01;
      tick(); inj_vld = 2'b00; #1;
      chk("s4_err", 64'(err), 64'h1);
      chk("s4_rsp_vld", 64'(rsp_vld), 64'h0);
      tick(); tick(); #1;
      chk("s4_err_sticky", 64'(err), 64'h1);
      chk("s4_rsp_vld_late", 64'(rsp_vld), 64'h0);

      // Reset with a read in flight.
      set_rd(2, 8'h42); #1;
      chk("s5_read", 64'(read), 64'h1);
      chk("s5_rd_adr", 64'(rd_adr), 64'h0042);
      tick(); clr_req(); rst = 1'b0; #1;
      chk("s5_err_clr", 64'(err), 64'h0);
      req_vld = 4'hF; #1;
      chk("s5_rst_rdy_rd", 64'(req_rdy), 64'h0);
      chk("s5_rst_read", 64'(read), 64'h0);
      req_wr = 4'hF; #1;
      chk("s5_rst_rdy_wr", 64'(req_rdy), 64'h0);
      chk("s5_rst_write", 64'(write), 64'h0);
      tick(); tick(); clr_req(); rst = 1'b1; #1;
      chk("s5_rel_rsp0", 64'(rsp_vld), 64'h0);
      tick(); #1;
      chk("s5_rel_rsp1", 64'(rsp_vld), 64'h0);
      tick(); #1;
      chk("s5_rel_rsp2", 64'(rsp_vld), 64'h0);
      chk("s5_rel_err", 64'(err), 64'h0);

      // Three cycles of four valid reads from pointer 0.
      set_rd(0, 8'h40); set_rd(1, 8'h41); set_rd(2, 8'h42); set_rd(3, 8'h43); #1;
      chk("s6_c0_rdy", 64'(req_rdy), 64'h3);
      chk("s6_c0_rd_adr", 64'(rd_adr), 64'h4140);
      tick(); #1;
      chk("s6_c1_rdy", 64'(req_rdy), 64'hC);
      tick(); #1;
      chk("s6_c2_rdy", 64'(req_rdy), 64'h3);
      tick(); clr_req(); #1;
      chk("s6_c3_rsp_vld", 64'(rsp_vld), 64'hC);
`ifdef ALGO_SCHED_PERF_CNT_EN
      chk("s6_rd_gnt_cnt", 64'(rd_gnt_cnt), 64'd6);
      chk("s6_stall_cnt", 64'(stall_cnt), 64'd3);
      chk("s6_wr_gnt_cnt", 64'(wr_gnt_cnt), 64'd0);
`endif
      tick(); #1;
      chk("s6_c4_rsp_vld", 64'(rsp_vld), 64'h3);
      chk("s6_c4_data0", 64'(rsp_data[14:0]), 64'h0A0A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
